// File: rtl/ps_frame_tx_pkg.sv
// ---------------------------------------------------------------------------
// ps_frame_tx_pkg
// Shared definitions for the ps feature frame transmitter:
//   - tx_state_e        : serializer FSM state encoding
//   - SYNC_BYTE_DEFAULT : default frame header byte
//   - calc_clog2()      : ceil(log2(value)), usable in constant expressions
//   - num_bytes()       : number of whole bytes needed to carry a word
// ---------------------------------------------------------------------------
package ps_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Returns 0 for value <= 1, otherwise the bits needed to index value items.
    function automatic int calc_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int num_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/ps_sync_fifo.sv
// ---------------------------------------------------------------------------
// ps_sync_fifo
// Single-clock FIFO buffering feature words between the ps datapath and the
// frame serializer. A push into a full FIFO is accepted when a pop happens in
// the same cycle, so the level stays at DEPTH in that case.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers/level -> 0)
//   push, din  : write request and data (ignored when full without a pop)
//   pop, dout  : read request and show-ahead read data (ignored when empty)
//   full/empty : status flags derived from the level counter
//   level      : number of words currently held (0..DEPTH)
// ---------------------------------------------------------------------------
module ps_sync_fifo
    import ps_frame_tx_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    output logic [WIDTH-1:0]              dout,
    output logic                          full,
    output logic                          empty,
    output logic [calc_clog2(DEPTH):0]    level
);

    localparam int AW = calc_clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             pop_ok;
    logic             push_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when a word leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Pointer wrap relies on DEPTH being a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ps_frame_tx.sv
// ---------------------------------------------------------------------------
// ps_frame_tx
// Captures signed feature words from the ps datapath into a small FIFO and
// serializes each into a frame of NB+2 bytes on a byte-wide valid/ready link:
//   sync byte, NB data bytes (sign-extended word, LSB first), XOR checksum of
//   the data bytes. Back-to-back frames are sent without a gap cycle.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (aborts any frame)
//   en          : active-low capture enable (high suppresses new captures)
//   feat_din    : signed feature word, captured when feat_valid is high
//   feat_valid  : one-cycle capture strobe
//   tx_data     : registered frame byte
//   tx_valid    : registered byte-valid, held until accepted
//   tx_ready    : downstream accepts the byte when tx_valid && tx_ready
//   fifo_level  : words currently buffered
//   busy        : a frame is in progress
//   overflow    : sticky, a strobe was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ps_frame_tx
    import ps_frame_tx_pkg::*;
#(
    parameter int         DATA_WIDTH = 40,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [DATA_WIDTH-1:0]             feat_din,
    input  logic                              feat_valid,
    output logic [7:0]                        tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic [calc_clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                              busy,
    output logic                              overflow
);

    localparam int NB    = num_bytes(DATA_WIDTH);
    localparam int NBITS = NB * 8;
    localparam int IDX_W = (NB > 1) ? calc_clog2(NB) : 1;

    tx_state_e          state_q, state_d;
    logic [NBITS-1:0]   sh_q, sh_d;
    logic [7:0]         csum_q, csum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               overflow_q, overflow_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [NBITS-1:0]   word_ext;
    logic [NBITS-1:0]   sh_next;
    logic [7:0]         csum_next;
    logic               accept;
    logic               start_frame;

    assign fifo_push = feat_valid && !en;

    ps_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (feat_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The size cast of a signed value replicates the sign bit into the top byte(s).
    assign word_ext  = NBITS'($signed(fifo_dout));
    assign sh_next   = sh_q >> 8;
    assign csum_next = csum_q ^ tx_data_q;
    assign accept    = tx_valid_q && tx_ready;

    // Next-state and registered-output logic. The byte for the following
    // state is computed here so that tx_data/tx_valid come straight from flops.
    // The shift register always holds the current data byte in its low 8 bits.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    tx_data_d = sh_q[7:0];
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d = csum_next;
                    sh_d   = sh_next;
                    if (idx_q == IDX_W'(NB - 1)) begin
                        tx_data_d = csum_next;
                        state_d   = ST_CSUM;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_data_d = sh_next[7:0];
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
                state_d    = ST_IDLE;
            end
        endcase

        // Shared by IDLE and the no-bubble restart out of CSUM.
        if (start_frame) begin
            fifo_pop   = 1'b1;
            sh_d       = word_ext;
            csum_d     = 8'h00;
            idx_d      = '0;
            tx_data_d  = SYNC_BYTE;
            tx_valid_d = 1'b1;
            state_d    = ST_HDR;
        end
    end

    // A strobe is lost only if the FIFO is full and nothing leaves this cycle.
    assign overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            csum_q     <= 8'h00;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            csum_q     <= csum_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_ps_frame_tx
// Directed bench for ps_frame_tx. Each issued strobe pushes its expected
// frame bytes into a queue; a negedge monitor pops and compares every byte
// the DUT hands over, and also checks that stalled bytes stay stable.
// ---------------------------------------------------------------------------
module tb_ps_frame_tx;

    logic        clk;
    logic        rst;
    logic        en;
    logic [39:0] feat_din;
    logic        feat_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        overflow;

    int          totalCount;
    int          badCount;
    logic [7:0]  expQ[$];
    int          nCycles;

    ps_frame_tx #(
        .DATA_WIDTH (40),
        .FIFO_DEPTH (4),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .feat_din   (feat_din),
        .feat_valid (feat_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .overflow   (overflow)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Expected frame: sync, five bytes LSB first, XOR of those five bytes.
    task automatic pushFrame(input logic [39:0] word);
        logic [7:0] b;
        logic [7:0] cs;
        cs = 8'h00;
        expQ.push_back(8'hA5);
        for (int i = 0; i < 5; i++) begin
            b  = word[8*i +: 8];
            cs = cs ^ b;
            expQ.push_back(b);
        end
        expQ.push_back(cs);
    endtask

    // One-cycle strobe; called #1 after a posedge, returns #1 after the capture edge.
    task automatic applyStimulus(input logic [39:0] word, input bit willSend);
        if (willSend) pushFrame(word);
        feat_din   = word;
        feat_valid = 1'b1;
        @(posedge clk);
        #1;
        feat_valid = 1'b0;
    endtask

    // Waits (bounded) until every expected byte has been seen; n = posedges waited.
    task automatic waitDrain(input int limit, output int n);
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (expQ.size() != 0) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL drain_timeout: got %0d bytes left, want 0", expQ.size());
        end
    endtask

    // Monitor: compares every accepted byte against the scoreboard and checks
    // that a byte presented but not accepted is held unchanged next cycle.
    always @(negedge clk) begin : monitor
        logic       prevHold;
        logic [7:0] prevData;
        logic [7:0] e;
        if (rst) begin
            prevHold = 1'b0;
            prevData = 8'h00;
        end else begin
            if (prevHold) begin
                checkOutput("hold_valid", tx_valid, 1'b1);
                checkOutput("hold_data", tx_data, prevData);
            end
            if (tx_valid && tx_ready) begin
                if (expQ.size() == 0) begin
                    totalCount++;
                    badCount++;
                    $display("[TB] FAIL unexpected_byte: got %0h, want no byte", tx_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("frame_byte", tx_data, e);
                end
            end
            prevHold = tx_valid && !tx_ready;
            prevData = tx_data;
        end
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        totalCount = 0;
        badCount   = 0;
        rst        = 1'b1;
        en         = 1'b0;
        feat_din   = '0;
        feat_valid = 1'b0;
        tx_ready   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_tx_valid", tx_valid, 1'b0);
        checkOutput("rst_level", fifo_level, 3'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word with header latency of two cycles after the strobe cycle.
        $display("[TB] single word");
        tx_ready = 1'b1;
        applyStimulus(40'h00_1234_5678, 1'b1);
        checkOutput("lat_t1_valid", tx_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("lat_t2_valid", tx_valid, 1'b1);
        checkOutput("lat_t2_data", tx_data, 8'hA5);
        waitDrain(50, nCycles);
        checkOutput("single_cycles", nCycles, 7);
        checkOutput("single_end_valid", tx_valid, 1'b0);
        checkOutput("single_end_busy", busy, 1'b0);

        // Negative words exercise sign extension into the top byte.
        $display("[TB] negative words");
        applyStimulus(40'hFF_FFFF_FFFF, 1'b1);
        applyStimulus(40'hFF_FFFF_FFFE, 1'b1);
        waitDrain(100, nCycles);
        checkOutput("neg_end_busy", busy, 1'b0);

        // Backpressure: ready low in even cycles, high in odd ones.
        $display("[TB] backpressure");
        tx_ready = 1'b0;
        applyStimulus(40'h00_1234_5678, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("bp_hdr_valid", tx_valid, 1'b1);
        for (int i = 0; i < 14; i++) begin
            tx_ready = (i % 2 == 1);
            if (i == 12) checkOutput("bp_remaining", expQ.size(), 1);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        checkOutput("bp_done", expQ.size(), 0);
        checkOutput("bp_end_valid", tx_valid, 1'b0);

        // Burst of six while stalled: word 1 is already in the serializer,
        // words 2..5 fill the FIFO and word 6 is dropped.
        $display("[TB] burst and overflow");
        for (int v = 1; v <= 6; v++) begin
            applyStimulus(40'(v), v <= 5);
        end
        checkOutput("burst_level", fifo_level, 3'd4);
        checkOutput("burst_overflow", overflow, 1'b1);
        tx_ready = 1'b1;
        waitDrain(200, nCycles);
        checkOutput("burst_cycles", nCycles, 35);
        checkOutput("burst_overflow_sticky", overflow, 1'b1);
        checkOutput("burst_end_level", fifo_level, 3'd0);

        // Full FIFO with a strobe exactly when the serializer pops.
        $display("[TB] full with simultaneous pop");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        tx_ready = 1'b0;
        for (int v = 'h11; v <= 'h15; v++) begin
            applyStimulus(40'(v), 1'b1);
        end
        checkOutput("fp_level_full", fifo_level, 3'd4);
        tx_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(40'h16, 1'b1);
        checkOutput("fp_level_kept", fifo_level, 3'd4);
        checkOutput("fp_no_overflow", overflow, 1'b0);
        waitDrain(200, nCycles);
        checkOutput("fp_cycles", nCycles, 35);
        checkOutput("fp_end_overflow", overflow, 1'b0);

        // Reset during the fourth byte aborts the frame for good.
        $display("[TB] reset mid-frame");
        applyStimulus(40'h00_1234_5678, 1'b1);
        nCycles = 0;
        while (expQ.size() != 4 && nCycles < 20) begin
            @(posedge clk);
            #1;
            nCycles++;
        end
        checkOutput("rm_reached_byte4", expQ.size(), 4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rm_tx_valid", tx_valid, 1'b0);
        checkOutput("rm_tx_data", tx_data, 8'h00);
        checkOutput("rm_busy", busy, 1'b0);
        checkOutput("rm_level", fifo_level, 3'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rm_no_resume_valid", tx_valid, 1'b0);
        checkOutput("rm_no_resume_busy", busy, 1'b0);

        // en high suppresses captures.
        $display("[TB] capture disabled");
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(40'h77, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("en_level", fifo_level, 3'd0);
        checkOutput("en_overflow", overflow, 1'b0);
        checkOutput("en_tx_valid", tx_valid, 1'b0);
        en = 1'b0;

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
